cr_host_port: RTL

- Host-side serial front end that drives transactions into the control register over the control register interface.
- Deserializes tester frames (R/W bit, address, data), issues one write or read transaction per frame and waits for the register's ack.
- For reads, serializes the returned data back to the tester.
- Sits between the chip's tester pins (already synchronized into CLK) and the control register block.

---
 rtl/cr_host_port_pkg.sv | 26 ++
 rtl/cr_host_shifter.sv | 35 +++
 rtl/cr_host_port.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/cr_host_port_pkg.sv
// Shared types and constants for the control-register host port.
// Widths and defaults here are also used by the control register block.
package cr_host_port_pkg;

    localparam int CR_ADDR_W  = 4;
    localparam int CR_DATA_W  = 8;
    localparam int CR_TIMEOUT = 15;

    typedef logic [CR_ADDR_W-1:0] cr_addr_t;
    typedef logic [CR_DATA_W-1:0] cr_data_t;

    typedef logic [2:0] hp_state_t;

    localparam hp_state_t HP_IDLE     = 3'd0;
    localparam hp_state_t HP_SHIFT    = 3'd1;
    localparam hp_state_t HP_ISSUE    = 3'd2;
    localparam hp_state_t HP_WAIT_ACK = 3'd3;
    localparam hp_state_t HP_REPLY    = 3'd4;
    localparam hp_state_t HP_DONE     = 3'd5;

    // Frame is R/W bit, then address, then data.
    function automatic int hp_frame_w(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

endpackage

// File: rtl/cr_host_shifter.sv
// Parallel-load shift register with bit counter. Deserializes tester frames
// (shift in at LSB) and serializes read replies (MSB leaves first).
module cr_host_shifter #(
    parameter int W     = 13,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             load,
    input  logic [W-1:0]     ld_data,
    input  logic             restart,
    input  logic             shift,
    input  logic             bit_in,
    output logic [W-1:0]     sh,
    output logic [CNT_W-1:0] cnt
);

    // load beats restart beats shift; restart seeds a fresh frame with its first bit
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sh  <= '0;
            cnt <= '0;
        end else if (load) begin
            sh  <= ld_data;
            cnt <= '0;
        end else if (restart) begin
            sh  <= {{(W-1){1'b0}}, bit_in};
            cnt <= CNT_W'(1);
        end else if (shift) begin
            sh  <= {sh[W-2:0], bit_in};
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cr_host_port.sv
// Host-side serial front end: collects a tester frame, issues one control
// register read or write, waits for ack (with timeout) and shifts read data
// back out MSB first.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a rising edge of ser_en
// SHIFT    | collecting frame bits while ser_en stays high
// ISSUE    | latch addr/wdata, raise wr_en or rd_en
// WAIT_ACK | request held, ack timer running
// REPLY    | read data leaving on ser_out, DATA_W cycles
// DONE     | transaction finished, waiting for ser_en low
module cr_host_port
    import cr_host_port_pkg::*;
#(
    parameter int ADDR_W  = CR_ADDR_W,
    parameter int DATA_W  = CR_DATA_W,
    parameter int TIMEOUT = CR_TIMEOUT
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ser_en,
    input  logic              ser_in,
    output logic              ser_out,
    output logic              ser_out_valid,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              ack,
    output logic              busy,
    output logic              err
);

    localparam int FRAME_W = hp_frame_w(ADDR_W, DATA_W);
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int TMR_W   = $clog2(TIMEOUT + 1);
    // Timer counts down from TIMEOUT-1 so that the request is held exactly
    // TIMEOUT cycles when the terminal count is reached without ack.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    hp_state_t           state_q;
    hp_state_t           state_d;
    logic                ser_en_q;
    logic [TMR_W-1:0]    tmr_q;
    logic                err_q;
    logic                wr_en_q;
    logic                rd_en_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                sh_load;
    logic                sh_restart;
    logic                sh_shift;
    logic                sh_bit;
    logic [FRAME_W-1:0]  sh_ld_data;
    logic [FRAME_W-1:0]  sh;
    logic [CNT_W-1:0]    sh_cnt;

    logic                frame_start;
    logic                tmr_tc;

    assign frame_start = ser_en && !ser_en_q;
    assign tmr_tc      = (tmr_q == '0);

    cr_host_shifter #(
        .W     (FRAME_W),
        .CNT_W (CNT_W)
    ) u_shifter (
        .CLK     (CLK),
        .nRST    (nRST),
        .load    (sh_load),
        .ld_data (sh_ld_data),
        .restart (sh_restart),
        .shift   (sh_shift),
        .bit_in  (sh_bit),
        .sh      (sh),
        .cnt     (sh_cnt)
    );

    // Next-state decode and shifter control
    always_comb begin
        state_d    = state_q;
        sh_load    = 1'b0;
        sh_restart = 1'b0;
        sh_shift   = 1'b0;
        sh_bit     = ser_in;
        sh_ld_data = {rdata, {(FRAME_W-DATA_W){1'b0}}};
        case (state_q)
            HP_IDLE: begin
                if (frame_start) begin
                    sh_restart = 1'b1;
                    state_d    = HP_SHIFT;
                end
            end
            HP_SHIFT: begin
                if (ser_en) begin
                    sh_shift = 1'b1;
                    if (sh_cnt == CNT_W'(FRAME_W - 1)) begin
                        state_d = HP_ISSUE;
                    end
                end else begin
                    state_d = HP_IDLE;
                end
            end
            HP_ISSUE: begin
                state_d = HP_WAIT_ACK;
            end
            HP_WAIT_ACK: begin
                if (ack) begin
                    if (rd_en_q) begin
                        sh_load = 1'b1;
                        state_d = HP_REPLY;
                    end else begin
                        state_d = HP_DONE;
                    end
                end else if (tmr_tc) begin
                    state_d = HP_DONE;
                end
            end
            HP_REPLY: begin
                sh_shift = 1'b1;
                sh_bit   = 1'b0;
                if (sh_cnt == CNT_W'(DATA_W - 1)) begin
                    state_d = HP_DONE;
                end
            end
            HP_DONE: begin
                if (!ser_en) begin
                    state_d = HP_IDLE;
                end
            end
            default: begin
                state_d = HP_IDLE;
            end
        endcase
    end

    // State register and ser_en history for edge detection
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= HP_IDLE;
            ser_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ser_en_q <= ser_en;
        end
    end

    // Request, address/data latches and ack timer
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            tmr_q   <= '0;
        end else begin
            case (state_q)
                HP_ISSUE: begin
                    addr_q  <= sh[FRAME_W-2 -: ADDR_W];
                    wdata_q <= sh[DATA_W-1:0];
                    wr_en_q <= sh[FRAME_W-1];
                    rd_en_q <= !sh[FRAME_W-1];
                    tmr_q   <= TMR_LOAD;
                end
                HP_WAIT_ACK: begin
                    if (ack || tmr_tc) begin
                        wr_en_q <= 1'b0;
                        rd_en_q <= 1'b0;
                        tmr_q   <= '0;
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sticky error: set by short frame or timeout, cleared at frame start
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err_q <= 1'b0;
        end else if (state_q == HP_IDLE && frame_start) begin
            err_q <= 1'b0;
        end else if (state_q == HP_SHIFT && !ser_en) begin
            err_q <= 1'b1;
        end else if (state_q == HP_WAIT_ACK && !ack && tmr_tc) begin
            err_q <= 1'b1;
        end
    end

    assign wr_en         = wr_en_q;
    assign rd_en         = rd_en_q;
    assign addr          = addr_q;
    assign wdata         = wdata_q;
    assign err           = err_q;
    assign busy          = (state_q != HP_IDLE);
    assign ser_out_valid = (state_q == HP_REPLY);
    assign ser_out       = (state_q == HP_REPLY) && sh[FRAME_W-1];

endmodule
